qpsk_corr_demod_p: RTL
======================

// Module: qpsk_corr_demod_p
// PURPOSE
//  Parametrised QPSK correlation demodulator, next generation of the receiver demodulator.
//  Sits between channel model/ADC and symbol sink; hunts for a burst head, then integrates
//  channel_out against the local Sin/Cos references and emits 2-bit symbol decisions.
//  Adds generic widths, decimation, symbol length, lock timeout, re-arm and valid/ready output.
// PARAMETERS
//  DATA_W     9    signed width of channel_out, GetSin, GetCos
//  ACC_W      20   signed accumulator width; must be >= 2*DATA_W
//  CNT_W      7    width of recev_read; must hold SYM_LEN
//  DECIM      4    clocks per processed sample (>=1)
//  SYM_LEN    32   sample slots per symbol (>=2)
//  DET_THRESH 60   head detect: |channel_out| > DET_THRESH (strict)
//  SEED_GAIN  100  sum_Q seed = SEED_GAIN*channel_out at head/symbol start; 0 = no seed
//  MAX_SYMS   0    symbols before auto-unlock to HUNT; 0 = never
// PORTS
//  clk               in   1       clock
//  reset             in   1       synchronous reset, active-high
//  rearm             in   1       force HUNT on next edge
//  GetSin            in   DATA_W  signed in-phase reference
//  GetCos            in   DATA_W  signed quadrature reference
//  channel_out       in   DATA_W  signed received sample
//  demod_ready       in   1       sink accepts demod_out
//  demodulation_out  out  2       symbol decision
//  demod_valid       out  1       demodulation_out valid
//  overrun           out  1       sticky: undelivered decision overwritten
//  locked            out  1       1 in INTEG state
//  recev_read        out  CNT_W   sample index within symbol (1..SYM_LEN), 0 in HUNT
// BEHAVIOUR
//  Reset (sync, highest priority): state HUNT; every output and internal register = 0.
//  Reset mid-symbol: sums, counters and pending output discarded at that edge.
//  HUNT: on edge with |channel_out| > DET_THRESH -> INTEG, recev_read=1, decim_cnt=0,
//    sum_I=0, sum_Q=SEED_GAIN*sext(channel_out), sym_cnt=0.
//  INTEG: decim_cnt increments every clock, wraps modulo DECIM.
//    Edge with decim_cnt==DECIM-1 (sample slot):
//      recev_read<SYM_LEN: sum_I+=x*GetSin, sum_Q+=x*GetCos, recev_read++.
//      recev_read==SYM_LEN: decide from {sum_I[MSB],sum_Q[MSB]}:
//        00->01, 01->11, 10->00, 11->10; reseed sums from current sample as at detect;
//        recev_read=1; sym_cnt++; if MAX_SYMS!=0 and sym_cnt+1==MAX_SYMS -> HUNT after deciding.
//    Decision latency: DECIM*SYM_LEN edges after detect edge (128 at defaults).
//  Arithmetic: operands sign-extended to ACC_W, products/sums wrap modulo 2^ACC_W, no saturation.
//  rearm: HUNT next edge, recev_read=0; pending output kept; rearm+decision same edge -> decision
//    still issued. reset beats rearm.
//  Output handshake: decision loads demodulation_out, demod_valid=1; held until edge with
//    demod_valid&demod_ready -> demod_valid=0. New decision while valid and !ready: overwrite
//    data, overrun=1 (cleared only by reset). New decision with ready same edge: load, valid
//    stays 1, no overrun.
// CONFIGURATION
//  DEMOD_SOFT_OUT_EN defined: extra outputs soft_I, soft_Q (ACC_W, signed) = sum_I/sum_Q
//    captured at each decision, updated with demodulation_out; reset 0.
//  Not defined: ports absent, hard decisions only; all other behaviour identical.
// TESTING (defaults)
//  1 channel_out=+60 then -60 for 50 clk -> locked=0; then +61 -> next edge locked=1, recev_read=1.
//  2 detect x=+100 const, GetSin=GetCos=+50 -> edge t+128: sum_I=155000, sum_Q=165000,
//    demodulation_out=01, demod_valid=1.
//  3 as 2 with GetSin=-50 -> sum_I=-155000, demodulation_out=00; GetCos=-50 also
//    (sum_Q=10000-155000<0) -> 10.
//  4 demod_ready=0 over two decisions -> overrun=1, data = 2nd symbol; ready=1 one clk -> valid=0.
//  5 MAX_SYMS=2 -> locked drops on edge of 2nd decision; rearm at recev_read=10 -> locked=0, recev_read=0.
//  6 reset pulse at recev_read=20 with demod_valid=1 -> all outputs 0 next edge, re-detect needed.

Source files
------------

// File: rtl/qpsk_corr_demod_p.sv
// QPSK correlation demodulator: hunts for a burst head, integrates the received samples
// against Sin/Cos references and issues 2-bit symbol decisions over a valid/ready port.
// Optional soft-metric outputs (soft_I, soft_Q) are built when DEMOD_SOFT_OUT_EN is defined.
module qpsk_corr_demod_p #(
    parameter int DATA_W     = 9,
    parameter int ACC_W      = 20,
    parameter int CNT_W      = 7,
    parameter int DECIM      = 4,
    parameter int SYM_LEN    = 32,
    parameter int DET_THRESH = 60,
    parameter int SEED_GAIN  = 100,
    parameter int MAX_SYMS   = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rearm,
    input  logic signed [DATA_W-1:0] GetSin,
    input  logic signed [DATA_W-1:0] GetCos,
    input  logic signed [DATA_W-1:0] channel_out,
    input  logic                     demod_ready,
    output logic [1:0]               demodulation_out,
    output logic                     demod_valid,
    output logic                     overrun,
    output logic                     locked,
    output logic [CNT_W-1:0]         recev_read
`ifdef DEMOD_SOFT_OUT_EN
    ,
    output logic signed [ACC_W-1:0]  soft_I,
    output logic signed [ACC_W-1:0]  soft_Q
`endif
);

    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int SYM_W = (MAX_SYMS > 1) ? $clog2(MAX_SYMS + 1) : 1;

    localparam logic [0:0] S_HUNT  = 1'b0;
    localparam logic [0:0] S_INTEG = 1'b1;

    localparam logic [DEC_W-1:0]        DECIM_LAST = DEC_W'(DECIM - 1);
    localparam logic [DEC_W-1:0]        DEC_ONE    = DEC_W'(1);
    localparam logic [CNT_W-1:0]        SYM_LEN_C  = CNT_W'(SYM_LEN);
    localparam logic [CNT_W-1:0]        CNT_ONE    = CNT_W'(1);
    localparam logic [SYM_W-1:0]        SYM_ONE    = SYM_W'(1);
    localparam logic [SYM_W-1:0]        MAX_C      = SYM_W'(MAX_SYMS);
    localparam logic signed [ACC_W-1:0] DET_C      = ACC_W'(DET_THRESH);
    localparam logic signed [ACC_W-1:0] SEED_C     = ACC_W'(SEED_GAIN);

    logic [0:0]               r_state;
    logic [DEC_W-1:0]         r_decim_cnt;
    logic [CNT_W-1:0]         r_recev_read;
    logic [SYM_W-1:0]         r_sym_cnt;
    logic signed [ACC_W-1:0]  r_sum_i;
    logic signed [ACC_W-1:0]  r_sum_q;
    logic [1:0]               r_dec_out;
    logic                     r_valid;
    logic                     r_overrun;

    logic signed [ACC_W-1:0]  w_x_ext;
    logic signed [ACC_W-1:0]  w_sin_ext;
    logic signed [ACC_W-1:0]  w_cos_ext;
    logic signed [ACC_W-1:0]  w_abs;
    logic signed [ACC_W-1:0]  w_prod_i;
    logic signed [ACC_W-1:0]  w_prod_q;
    logic signed [ACC_W-1:0]  w_seed;
    logic                     w_detect;
    logic                     w_slot;
    logic                     w_sym_end;
    logic                     w_decide;
    logic                     w_max_hit;
    logic [1:0]               w_dec;

    // All arithmetic runs at ACC_W and wraps; ACC_W >= 2*DATA_W keeps |x| exact.
    assign w_x_ext   = {{(ACC_W-DATA_W){channel_out[DATA_W-1]}}, channel_out};
    assign w_sin_ext = {{(ACC_W-DATA_W){GetSin[DATA_W-1]}}, GetSin};
    assign w_cos_ext = {{(ACC_W-DATA_W){GetCos[DATA_W-1]}}, GetCos};
    assign w_abs     = w_x_ext[ACC_W-1] ? -w_x_ext : w_x_ext;
    assign w_prod_i  = w_x_ext * w_sin_ext;
    assign w_prod_q  = w_x_ext * w_cos_ext;
    assign w_seed    = SEED_C * w_x_ext;
    assign w_detect  = (w_abs > DET_C);

    assign w_slot    = (r_decim_cnt == DECIM_LAST);
    assign w_sym_end = w_slot && (r_recev_read == SYM_LEN_C);
    assign w_decide  = (r_state == S_INTEG) && w_sym_end;
    assign w_max_hit = (MAX_SYMS != 0) && ((r_sym_cnt + SYM_ONE) == MAX_C);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_dec = 2'b00;
        case ({r_sum_i[ACC_W-1], r_sum_q[ACC_W-1]})
            2'b00:   w_dec = 2'b01;
            2'b01:   w_dec = 2'b11;
            2'b10:   w_dec = 2'b00;
            default: w_dec = 2'b10;
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is checked first so it beats rearm.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_HUNT;
            r_decim_cnt  <= '0;
            r_recev_read <= '0;
            r_sym_cnt    <= '0;
            r_sum_i      <= '0;
            r_sum_q      <= '0;
        end else begin
            case (r_state)
                S_HUNT: begin
                    if (!rearm && w_detect) begin
                        r_state      <= S_INTEG;
                        r_recev_read <= CNT_ONE;
                        r_decim_cnt  <= '0;
                        r_sum_i      <= '0;
                        r_sum_q      <= w_seed;
                        r_sym_cnt    <= '0;
                    end
                end
                default: begin
                    r_decim_cnt <= w_slot ? '0 : (r_decim_cnt + DEC_ONE);
                    if (w_slot) begin
                        if (!w_sym_end) begin
                            r_sum_i      <= r_sum_i + w_prod_i;
                            r_sum_q      <= r_sum_q + w_prod_q;
                            r_recev_read <= r_recev_read + CNT_ONE;
                        end else begin
                            r_sum_i      <= '0;
                            r_sum_q      <= w_seed;
                            r_recev_read <= CNT_ONE;
                            r_sym_cnt    <= r_sym_cnt + SYM_ONE;
                            if (w_max_hit) begin
                                r_state      <= S_HUNT;
                                r_recev_read <= '0;
                            end
                        end
                    end
                    // The decision above is still issued on a rearm edge; only the lock is dropped.
                    if (rearm) begin
                        r_state      <= S_HUNT;
                        r_recev_read <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dec_out <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_decide) begin
            r_dec_out <= w_dec;
            r_valid   <= 1'b1;
            if (r_valid && !demod_ready)
                r_overrun <= 1'b1;
        end else if (r_valid && demod_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef DEMOD_SOFT_OUT_EN
    logic signed [ACC_W-1:0] r_soft_i;
    logic signed [ACC_W-1:0] r_soft_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_soft_i <= '0;
            r_soft_q <= '0;
        end else if (w_decide) begin
            r_soft_i <= r_sum_i;
            r_soft_q <= r_sum_q;
        end
    end

    assign soft_I = r_soft_i;
    assign soft_Q = r_soft_q;
`else
    // Hard decisions only: the integrator sums stay internal.
`endif

    assign demodulation_out = r_dec_out;
    assign demod_valid      = r_valid;
    assign overrun          = r_overrun;
    assign locked           = (r_state == S_INTEG);
    assign recev_read       = r_recev_read;

endmodule
